dadda_mac_accumulator: RTL

Downstream stage of the pipelined Dadda 8x8 multiplier. Consumes the 16-bit product stream, sums a programmable-length block of products into a wide accumulator, and presents the block total on a valid/ready handshake. Used for dot-product and FIR-style sums built on the multiplier.

---
 rtl/dadda_mac_accumulator.sv | 110 +++++++++++
 1 files changed

// File: rtl/dadda_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dadda_mac_accumulator
// Purpose  : Sums a programmable-length block of multiplier products and hands
//            the block total over on a valid/ready handshake.
//            Optional macro DADDA_MAC_SATURATE_EN clamps on overflow instead
//            of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module dadda_mac_accumulator #(
  parameter int PROD_WIDTH  = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] block_len,
  input  logic [PROD_WIDTH-1:0]  product_in,
  input  logic                   product_valid,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [ACC_WIDTH-1:0]   acc, acc_next;
  logic [COUNT_WIDTH-1:0] remaining, remaining_next;
  logic                   ovf, ovf_next;

  logic [ACC_WIDTH:0]     sum;
  logic                   carry;
  logic                   accept_start;
  logic                   take_product;

  // One extra bit of headroom exposes the carry-out used for overflow.
  assign sum   = {1'b0, acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, product_in};
  assign carry = sum[ACC_WIDTH];

  assign accept_start = start && ((state == IDLE) || ((state == DONE) && result_ready));
  assign take_product = (state == ACCUM) && product_valid;

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    remaining_next = remaining;
    ovf_next       = ovf;

    case (state)
      IDLE, DONE: begin
        if (accept_start) begin
          acc_next       = '0;
          ovf_next       = 1'b0;
          remaining_next = block_len;
          state_next     = (block_len != '0) ? ACCUM : DONE;
        end else if ((state == DONE) && result_ready) begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (take_product) begin
`ifdef DADDA_MAC_SATURATE_EN
          acc_next = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
          acc_next = sum[ACC_WIDTH-1:0];
`endif
          if (carry) begin
            ovf_next = 1'b1;
          end
          remaining_next = remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) begin
            state_next = DONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      remaining <= remaining_next;
      ovf       <= ovf_next;
    end
  end

  assign result       = acc;
  assign result_valid = (state == DONE);
  assign busy         = (state == ACCUM);
  assign overflow     = ovf;

endmodule
`default_nettype wire
